serial_transmitter: RTL

- Serialises 7-bit words onto a single-wire line, LSB first, with an even parity bit.
- Frame: start(0), d0..d6, parity, STOP_BITS x stop(1). Line idles at 1.
- Sits on the TX side of the point-to-point serial link, driven by a valid/ready producer.
- At CLKS_PER_BIT=1 it emits one bit per clock, matching the team's one-sample-per-clock serial receiver.

---
 rtl/serial_pkg.sv | 10 +
 rtl/serial_bit_timer.sv | 17 +
 rtl/serial_transmitter.sv | 106 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared width, line levels, tx state encoding and even-parity helper for the serial link
package serial_pkg;
  localparam int SER_DATA_W = 7;
  localparam logic SER_START_LVL = 1'b0;
  localparam logic SER_IDLE_LVL = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  function automatic logic even_parity(input logic [SER_DATA_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: counts clocks within one frame bit and flags the last clock of that bit
// ports: clk, rstn (async active-low), clear (hold counter at 0), bit_end (counter at CLKS_PER_BIT-1)
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else cnt <= clear || bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: 7-bit LSB-first serialiser, frame = start, d0..d6, even parity, STOP_BITS stops
// ports: clk, rstn (async active-low), data_in/valid/ready (producer handshake),
//        serial_out (registered line, idles at 1), busy (frame in progress), tx_done (last stop-bit cycle)
// option: define TX_HOLD_BUF_EN for a one-entry holding buffer giving back-to-back frames
module serial_transmitter
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [SER_DATA_W-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  tx_done
);
  tx_state_e state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [SER_DATA_W-1:0] shift, shift_nxt, src;
  logic par, par_nxt, bit_end, accept, fin, load, last_stop, ready_nxt, so_nxt;
  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .clear(state == IDLE),
    .bit_end(bit_end)
  );
  assign accept = valid && ready;
  assign last_stop = idx == 3'(STOP_BITS - 1);
  assign fin = state == STOP && bit_end && last_stop;
  assign tx_done = fin;
`ifdef TX_HOLD_BUF_EN
  logic buf_full, buf_full_nxt;
  logic [SER_DATA_W-1:0] buf_data;
  // a word arriving on the final stop edge with an empty buffer chains directly, like a buffered one
  assign load = (state == IDLE && accept) || (fin && (buf_full || accept));
  assign src = buf_full ? buf_data : data_in;
  assign buf_full_nxt = accept && state != IDLE && !fin ? 1'b1 : fin ? 1'b0 : buf_full;
  assign ready_nxt = !buf_full_nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      buf_full <= buf_full_nxt;
      buf_data <= buf_full_nxt && !buf_full ? data_in : buf_data;
    end
`else
  assign load = state == IDLE && accept;
  assign src = data_in;
  assign ready_nxt = state_nxt == IDLE;
`endif
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    case (state)
      START: if (bit_end) begin
        state_nxt = DATA;
        idx_nxt = '0;
      end
      DATA: if (bit_end) begin
        state_nxt = idx == 3'(SER_DATA_W - 1) ? PARITY : DATA;
        idx_nxt = idx == 3'(SER_DATA_W - 1) ? 3'd0 : idx + 3'd1;
      end
      PARITY: if (bit_end) begin
        state_nxt = STOP;
        idx_nxt = '0;
      end
      STOP: if (bit_end) begin
        state_nxt = last_stop ? IDLE : STOP;
        idx_nxt = last_stop ? 3'd0 : idx + 3'd1;
      end
      default: ;
    endcase
    if (load) begin
      state_nxt = START;
      idx_nxt = '0;
    end
  end
  assign shift_nxt = load ? src : shift;
  assign par_nxt = load ? even_parity(src) : par;
  // the line flop is loaded with the bit of the state being entered, so it tracks the FSM without lag
  assign so_nxt = state_nxt == START ? SER_START_LVL :
                  state_nxt == DATA ? shift_nxt[idx_nxt] :
                  state_nxt == PARITY ? par_nxt : SER_IDLE_LVL;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      idx <= '0;
      shift <= '0;
      par <= 1'b0;
      serial_out <= SER_IDLE_LVL;
      ready <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      shift <= shift_nxt;
      par <= par_nxt;
      serial_out <= so_nxt;
      ready <= ready_nxt;
      busy <= state_nxt != IDLE;
    end
endmodule
